// File: rtl/uart_tx_sequencer.sv
// AXI-Lite master that programs the UART control register once after reset, then
// streams each accepted console byte into the UART TX FIFO, polling status while it is full.
module uart_tx_sequencer #(
   parameter logic [12:0] TX_OFFSET   = 13'h004,
   parameter logic [12:0] STAT_OFFSET = 13'h008,
   parameter logic [12:0] CTRL_OFFSET = 13'h00C,
   parameter logic [31:0] INIT_CTRL   = 32'h0000_0003,
   parameter int unsigned TX_FULL_BIT = 3,
   parameter int unsigned POLL_GAP    = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [12:0] m_axi_uart_awaddr,
   output logic        m_axi_uart_awvalid,
   input  logic        m_axi_uart_awready,
   output logic [31:0] m_axi_uart_wdata,
   output logic [3:0]  m_axi_uart_wstrb,
   output logic        m_axi_uart_wvalid,
   input  logic        m_axi_uart_wready,
   input  logic [1:0]  m_axi_uart_bresp,
   input  logic        m_axi_uart_bvalid,
   output logic        m_axi_uart_bready,
   output logic [12:0] m_axi_uart_araddr,
   output logic        m_axi_uart_arvalid,
   input  logic        m_axi_uart_arready,
   input  logic [31:0] m_axi_uart_rdata,
   input  logic [1:0]  m_axi_uart_rresp,
   input  logic        m_axi_uart_rvalid,
   output logic        m_axi_uart_rready
);

   localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   typedef enum logic [2:0] {
      S_INIT_W, S_INIT_B, S_IDLE, S_POLL_AR, S_POLL_R, S_GAP, S_WR, S_WR_B
   } state_e;

   state_e             state_q;
   logic               awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic               aw_done_q, w_done_q;
   logic [12:0]        awaddr_q, araddr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         wstrb_q;
   logic [7:0]         byte_q;
   logic               tx_ready_q, busy_q, err_q;
   logic [GAP_W-1:0]   gap_cnt_q;

   logic aw_fire, w_fire, aw_ok, w_ok, is_init, status_full, unused_rdata;

   assign aw_fire     = awvalid_q & m_axi_uart_awready;
   assign w_fire      = wvalid_q & m_axi_uart_wready;
   assign aw_ok       = aw_done_q | aw_fire;
   assign w_ok        = w_done_q | w_fire;
   assign is_init     = (state_q == S_INIT_W);
   assign status_full = m_axi_uart_rdata[TX_FULL_BIT] && (m_axi_uart_rresp == 2'b00);
   assign unused_rdata = ^m_axi_uart_rdata;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= S_INIT_W;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         byte_q     <= '0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b1;
         err_q      <= 1'b0;
         gap_cnt_q  <= '0;
      end else begin
         case (state_q)
            // NOTE: valids are registered and cleared only after their own handshake,
            // so they never depend combinationally on the slave's ready.
            S_INIT_W, S_WR: begin
               if (!awvalid_q && !aw_done_q) begin
                  awvalid_q <= 1'b1;
                  awaddr_q  <= is_init ? CTRL_OFFSET : TX_OFFSET;
               end else if (aw_fire) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (!wvalid_q && !w_done_q) begin
                  wvalid_q <= 1'b1;
                  wdata_q  <= is_init ? INIT_CTRL : {24'h0, byte_q};
                  wstrb_q  <= is_init ? 4'hF : 4'h1;
               end else if (w_fire) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if (aw_ok && w_ok) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= is_init ? S_INIT_B : S_WR_B;
               end
            end
            S_INIT_B, S_WR_B: begin
               if (m_axi_uart_bvalid) begin
                  bready_q   <= 1'b0;
                  tx_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
                  if (m_axi_uart_bresp != 2'b00) err_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (tx_valid_i) begin
                  byte_q     <= tx_data_i;
                  tx_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  arvalid_q  <= 1'b1;
                  araddr_q   <= STAT_OFFSET;
                  state_q    <= S_POLL_AR;
               end
            end
            S_POLL_AR: begin
               if (m_axi_uart_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_POLL_R;
               end
            end
            S_POLL_R: begin
               if (m_axi_uart_rvalid) begin
                  rready_q <= 1'b0;
                  if (status_full) begin
                     gap_cnt_q <= '0;
                     state_q   <= S_GAP;
                  end else begin
                     if (m_axi_uart_rresp != 2'b00) err_q <= 1'b1;
                     state_q <= S_WR;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
                  arvalid_q <= 1'b1;
                  araddr_q  <= STAT_OFFSET;
                  state_q   <= S_POLL_AR;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            default: state_q <= S_INIT_W;
         endcase
      end
   end

   assign tx_ready_o         = tx_ready_q;
   assign busy_o             = busy_q;
   assign err_o              = err_q;
   assign m_axi_uart_awaddr  = awaddr_q;
   assign m_axi_uart_awvalid = awvalid_q;
   assign m_axi_uart_wdata   = wdata_q;
   assign m_axi_uart_wstrb   = wstrb_q;
   assign m_axi_uart_wvalid  = wvalid_q;
   assign m_axi_uart_bready  = bready_q;
   assign m_axi_uart_araddr  = araddr_q;
   assign m_axi_uart_arvalid = arvalid_q;
   assign m_axi_uart_rready  = rready_q;

endmodule
